// File: rtl/branch_predictor_bht_pkg.sv
// Shared constants and helpers for the BHT/BTB branch predictor: index width,
// PC index/tag bit positions and the weakly-not-taken counter reset value.
package branch_predictor_bht_pkg;

    // pc[1:0] is ignored; the index starts at bit 2.
    localparam int unsigned PcIdxLsb = 2;

    function automatic int unsigned bp_idx_w(input int unsigned entries);
        return $clog2(entries);
    endfunction

    function automatic int unsigned bp_tag_lsb(input int unsigned idx_w);
        return idx_w + PcIdxLsb;
    endfunction

    // Weakly-not-taken: 2^(cnt_w-1)-1, which is 0 for a 1-bit counter.
    function automatic int unsigned bp_weak_nt(input int unsigned cnt_w);
        return (32'd1 << (cnt_w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/branch_predictor_bht_sat_counter.sv
// CNT_W-bit saturating up/down counter with synchronous reset and enable.
module branch_predictor_bht_sat_counter #(
    parameter int unsigned CNT_W = 2,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (up && (cnt_q != {CNT_W{1'b1}})) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else if (!up && (cnt_q != '0)) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= RST_VAL;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_predictor_bht.sv
// Per-PC saturating-counter BHT plus tagged BTB with branch/mispredict counters.
// Define BP_GSHARE_EN to XOR a global history register into the BHT index.
module branch_predictor_bht
    import branch_predictor_bht_pkg::*;
#(
    parameter int unsigned ENTRIES = 64,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned TAG_W   = 8,
    parameter int unsigned GHR_W   = 6
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] fetch_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_mispredict,
    output logic [31:0] br_count,
    output logic [31:0] miss_count
);

    localparam int unsigned IdxW   = bp_idx_w(ENTRIES);
    localparam int unsigned TagLsb = bp_tag_lsb(IdxW);
    localparam logic [CNT_W-1:0] CntRst = CNT_W'(bp_weak_nt(CNT_W));

    logic [IdxW-1:0]  fidx, uidx, bht_fidx, bht_uidx;
    logic [TAG_W-1:0] ftag, utag;

    assign fidx = fetch_pc[IdxW+PcIdxLsb-1:PcIdxLsb];
    assign uidx = upd_pc[IdxW+PcIdxLsb-1:PcIdxLsb];
    assign ftag = fetch_pc[TagLsb+TAG_W-1:TagLsb];
    assign utag = upd_pc[TagLsb+TAG_W-1:TagLsb];

    // Bits above the tag and pc[1:0] do not participate in the lookup.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc, upd_pc};

`ifdef BP_GSHARE_EN
    logic [GHR_W-1:0] ghr_q, ghr_d;

    always_comb begin
        ghr_d = ghr_q;
        if (upd_valid) begin
            ghr_d = (ghr_q << 1) | GHR_W'(upd_taken);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ghr_q <= '0;
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign bht_fidx = fidx ^ IdxW'(ghr_q);
    assign bht_uidx = uidx ^ IdxW'(ghr_q);
`else
    localparam int unsigned unused_ghr_w = GHR_W;

    assign bht_fidx = fidx;
    assign bht_uidx = uidx;
`endif

    // Branch history table.
    logic [CNT_W-1:0] cnt [ENTRIES];

    for (genvar i = 0; i < ENTRIES; i++) begin : g_bht
        branch_predictor_bht_sat_counter #(
            .CNT_W  (CNT_W),
            .RST_VAL(CntRst)
        ) u_cnt (
            .clk  (clk),
            .rst  (rst),
            .en   (upd_valid && (bht_uidx == IdxW'(i))),
            .up   (upd_taken),
            .cnt_o(cnt[i])
        );
    end

    // Branch target buffer; tag/target storage is qualified by valid only.
    logic [ENTRIES-1:0] btb_valid_q, btb_valid_d;
    logic [TAG_W-1:0]   btb_tag_q    [ENTRIES];
    logic [TAG_W-1:0]   btb_tag_d    [ENTRIES];
    logic [31:0]        btb_target_q [ENTRIES];
    logic [31:0]        btb_target_d [ENTRIES];

    always_comb begin
        btb_valid_d  = btb_valid_q;
        btb_tag_d    = btb_tag_q;
        btb_target_d = btb_target_q;
        if (upd_valid && upd_taken) begin
            btb_valid_d[uidx]  = 1'b1;
            btb_tag_d[uidx]    = utag;
            btb_target_d[uidx] = upd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid_q <= '0;
        end else begin
            btb_valid_q <= btb_valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            btb_tag_q    <= btb_tag_d;
            btb_target_q <= btb_target_d;
        end
    end

    // Lookup reads pre-update state; outputs are forced low while in reset.
    logic hit;
    always_comb begin
        hit         = !rst && btb_valid_q[fidx] && (btb_tag_q[fidx] == ftag);
        pred_taken  = hit && cnt[bht_fidx][CNT_W-1];
        pred_target = hit ? btb_target_q[fidx] : 32'd0;
    end

    // Performance counters.
    logic [31:0] br_count_q, br_count_d, miss_count_q, miss_count_d;

    always_comb begin
        br_count_d   = br_count_q;
        miss_count_d = miss_count_q;
        if (upd_valid) begin
            br_count_d   = br_count_q + 32'd1;
            miss_count_d = miss_count_q + {31'd0, upd_mispredict};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            br_count_q   <= '0;
            miss_count_q <= '0;
        end else begin
            br_count_q   <= br_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign br_count   = br_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Directed bench for branch_predictor_bht (ENTRIES=64, CNT_W=2, TAG_W=8).
module tb_branch_predictor_bht;

    logic        clk;
    logic        rst;
    logic [31:0] fetch_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic [31:0] br_count;
    logic [31:0] miss_count;

    branch_predictor_bht #(
        .ENTRIES(64),
        .CNT_W  (2),
        .TAG_W  (8),
        .GHR_W  (6)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fetch_pc      (fetch_pc),
        .pred_taken    (pred_taken),
        .pred_target   (pred_target),
        .upd_valid     (upd_valid),
        .upd_pc        (upd_pc),
        .upd_taken     (upd_taken),
        .upd_target    (upd_target),
        .upd_mispredict(upd_mispredict),
        .br_count      (br_count),
        .miss_count    (miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        uv;
        logic [31:0] upc;
        logic        ut;
        logic [31:0] utgt;
        logic        um;
        logic [31:0] fpc;
        logic        ept;
        logic [31:0] etgt;
    } vec_t;

    localparam int NumVecs = 20;
    vec_t vecs [NumVecs];

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic uv, input logic [31:0] upc, input logic ut,
                         input logic [31:0] utgt, input logic um, input logic [31:0] fpc);
        upd_valid      = uv;
        upd_pc         = upc;
        upd_taken      = ut;
        upd_target     = utgt;
        upd_mispredict = um;
        fetch_pc       = fpc;
    endtask

    // Presents an update at the next negedge and lets the following posedge take it.
    task automatic upd_cycle(input logic [31:0] upc, input logic ut, input logic [31:0] utgt);
        drive(1'b1, upc, ut, utgt, 1'b0, 32'h0);
        @(negedge clk);
    endtask

    initial begin
        // uv upc ut utgt um | fpc -> pred_taken pred_target
        vecs[0]  = '{1'b0, 32'h000, 1'b0, 32'h00,   1'b0, 32'h100, 1'b0, 32'h00};
        vecs[1]  = '{1'b1, 32'h100, 1'b1, 32'h80,   1'b1, 32'h100, 1'b0, 32'h00};
        vecs[2]  = '{1'b0, 32'h000, 1'b0, 32'h00,   1'b0, 32'h100, 1'b1, 32'h80};
        vecs[3]  = '{1'b1, 32'h100, 1'b1, 32'h80,   1'b0, 32'h100, 1'b1, 32'h80};
        vecs[4]  = '{1'b1, 32'h100, 1'b1, 32'h80,   1'b0, 32'h100, 1'b1, 32'h80};
        vecs[5]  = '{1'b1, 32'h100, 1'b1, 32'h80,   1'b0, 32'h100, 1'b1, 32'h80};
        vecs[6]  = '{1'b1, 32'h100, 1'b0, 32'h00,   1'b1, 32'h100, 1'b1, 32'h80};
        vecs[7]  = '{1'b0, 32'h000, 1'b0, 32'h00,   1'b0, 32'h100, 1'b1, 32'h80};
        vecs[8]  = '{1'b1, 32'h100, 1'b0, 32'h00,   1'b0, 32'h100, 1'b1, 32'h80};
        vecs[9]  = '{1'b0, 32'h000, 1'b0, 32'h00,   1'b0, 32'h100, 1'b0, 32'h80};
        vecs[10] = '{1'b0, 32'h100, 1'b1, 32'hF0,   1'b1, 32'h100, 1'b0, 32'h80};
        vecs[11] = '{1'b0, 32'h000, 1'b0, 32'h00,   1'b0, 32'h100, 1'b0, 32'h80};
        vecs[12] = '{1'b1, 32'h100, 1'b1, 32'h80,   1'b0, 32'h100, 1'b0, 32'h80};
        vecs[13] = '{1'b1, 32'h200, 1'b1, 32'h40,   1'b0, 32'h100, 1'b1, 32'h80};
        vecs[14] = '{1'b0, 32'h000, 1'b0, 32'h00,   1'b0, 32'h100, 1'b0, 32'h00};
        vecs[15] = '{1'b0, 32'h000, 1'b0, 32'h00,   1'b0, 32'h200, 1'b1, 32'h40};
        vecs[16] = '{1'b0, 32'h000, 1'b0, 32'h00,   1'b0, 32'h104, 1'b0, 32'h00};
        vecs[17] = '{1'b0, 32'h000, 1'b0, 32'h00,   1'b0, 32'h203, 1'b1, 32'h40};
        vecs[18] = '{1'b1, 32'h104, 1'b1, 32'h1234, 1'b0, 32'h104, 1'b0, 32'h00};
        vecs[19] = '{1'b0, 32'h000, 1'b0, 32'h00,   1'b0, 32'h104, 1'b1, 32'h1234};

        rst = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);

        // An update presented during reset must be discarded (checked by vecs[16]).
        drive(1'b1, 32'h104, 1'b1, 32'h99, 1'b1, 32'h104);
        #1;
        chk("reset_pred_taken", {31'd0, pred_taken}, 32'd0);
        chk("reset_pred_target", pred_target, 32'd0);
        @(negedge clk);

        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h100);
        #1;
        chk("reset_br_count", br_count, 32'd0);
        chk("reset_miss_count", miss_count, 32'd0);
        @(negedge clk);

        for (int i = 0; i < NumVecs; i++) begin
            drive(vecs[i].uv, vecs[i].upc, vecs[i].ut, vecs[i].utgt, vecs[i].um, vecs[i].fpc);
            #1;
            chk($sformatf("vec%0d_pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].ept});
            chk($sformatf("vec%0d_pred_target", i), pred_target, vecs[i].etgt);
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        #1;
        chk("table_br_count", br_count, 32'd9);
        chk("table_miss_count", miss_count, 32'd2);

        // Mid-run reset: outputs low during reset, state cleared after.
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 32'h104, 1'b1, 32'h77, 1'b1, 32'h200);
        #1;
        chk("midrst_during_taken", {31'd0, pred_taken}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h200);
        #1;
        chk("midrst_after_taken", {31'd0, pred_taken}, 32'd0);
        chk("midrst_after_target", pred_target, 32'd0);
        chk("midrst_br_count", br_count, 32'd0);
        chk("midrst_miss_count", miss_count, 32'd0);
        fetch_pc = 32'h104;
        #1;
        chk("midrst_104_taken", {31'd0, pred_taken}, 32'd0);
        @(negedge clk);

        // No bypass: with a valid entry at counter 1, update 1->2 is seen a cycle later.
        upd_cycle(32'h100, 1'b1, 32'h80);
        upd_cycle(32'h100, 1'b0, 32'h0);
        drive(1'b1, 32'h100, 1'b1, 32'h80, 1'b0, 32'h100);
        #1;
        chk("nobypass_same_taken", {31'd0, pred_taken}, 32'd0);
        chk("nobypass_same_target", pred_target, 32'h80);
        @(negedge clk);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h100);
        #1;
        chk("nobypass_next_taken", {31'd0, pred_taken}, 32'd1);
        @(negedge clk);

        // Saturation at zero: 2 -> 1 -> 0 -> 0, then two takens to reach 2.
        repeat (3) upd_cycle(32'h300, 1'b0, 32'h0);
        upd_cycle(32'h300, 1'b1, 32'h30);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h300);
        #1;
        chk("satlo_cnt1_taken", {31'd0, pred_taken}, 32'd0);
        chk("satlo_cnt1_target", pred_target, 32'h30);
        @(negedge clk);
        upd_cycle(32'h300, 1'b1, 32'h30);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h300);
        #1;
        chk("satlo_cnt2_taken", {31'd0, pred_taken}, 32'd1);
        @(negedge clk);

        // Performance counters over 1000 updates, every 4th mispredicted.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            drive(1'b1, 32'(i) << 2, i[0], 32'(i), (i % 4) == 0, 32'h0);
            @(negedge clk);
        end
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
        @(negedge clk);
        chk("perf_br_count", br_count, 32'd1000);
        chk("perf_miss_count", miss_count, 32'd250);

        // History effect: after one taken update ghr=1, so 0x104 reads BHT entry 0.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        upd_cycle(32'h104, 1'b1, 32'h50);
        drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h104);
        #1;
`ifdef BP_GSHARE_EN
        chk("ghr_lookup_taken", {31'd0, pred_taken}, 32'd0);
`else
        chk("ghr_lookup_taken", {31'd0, pred_taken}, 32'd1);
`endif
        chk("ghr_lookup_target", pred_target, 32'h50);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
